// File: rtl/neuron_pulse_responder.sv
// -----------------------------------------------------------------------------
// neuron_pulse_responder
//
// Purpose:
//   This is the responder end of the neuron_trigger / neuron_idle handshake.
//   A one-cycle neuron_trigger starts one neuron operation, which runs through
//   three phases: SAMPLE, then INTEG, then LATCH. Each phase lasts a
//   programmable number of clk cycles. A length of 0 is treated as 1.
//   neuron_idle reports back to the initiator when the operation is complete.
//
// Optional feature:
//   NEURON_OPCNT_EN - when defined, the block builds an OPS_W-bit counter of
//                     completed operations and exposes it on op_count. When
//                     undefined, neither the port nor the counter exists.
//
// Ports:
//   clk            in   1      system clock
//   rst_n          in   1      asynchronous active-low reset
//   neuron_trigger in   1      start pulse, sampled on posedge clk
//   t_sample       in   CNT_W  SAMPLE phase length in cycles (0 -> 1)
//   t_integ        in   CNT_W  INTEG phase length in cycles (0 -> 1)
//   t_latch        in   CNT_W  LATCH phase length in cycles (0 -> 1)
//   overrun_clr    in   1      clears the sticky overrun flag
//   neuron_idle    out  1      1 = no operation in progress
//   sample_en      out  1      high during SAMPLE
//   integ_en       out  1      high during INTEG
//   latch_en       out  1      high during LATCH
//   overrun        out  1      sticky: trigger seen while busy
//   op_count       out  OPS_W  completed operations (NEURON_OPCNT_EN only)
// -----------------------------------------------------------------------------
module neuron_pulse_responder #(
    parameter int CNT_W = 16
`ifdef NEURON_OPCNT_EN
    ,
    parameter int OPS_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             neuron_trigger,
    input  logic [CNT_W-1:0] t_sample,
    input  logic [CNT_W-1:0] t_integ,
    input  logic [CNT_W-1:0] t_latch,
    input  logic             overrun_clr,
    output logic             neuron_idle,
    output logic             sample_en,
    output logic             integ_en,
    output logic             latch_en,
    output logic             overrun
`ifdef NEURON_OPCNT_EN
    ,
    output logic [OPS_W-1:0] op_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_INTEG  = 2'd2,
        S_LATCH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             overrun_reg, overrun_next;
    logic             neuron_idle_reg;
    logic             sample_en_reg;
    logic             integ_en_reg;
    logic             latch_en_reg;

    // Phase-length inputs in phase order (0 = SAMPLE, 1 = INTEG, 2 = LATCH).
    logic [CNT_W-1:0] t_len    [3];
    logic [CNT_W-1:0] load_val [3];

    assign t_len[0] = t_sample;
    assign t_len[1] = t_integ;
    assign t_len[2] = t_latch;

    // The counter counts down to 0 inclusive, so a phase of length L loads
    // L-1. A length of 0 maps to a load of 0, which gives one cycle. The
    // full-scale value loads 2^CNT_W-2, so the counter never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_load
            assign load_val[gi] = (t_len[gi] == '0) ? '0 : (t_len[gi] - CNT_ONE);
        end
    endgenerate

    // Next-state and counter logic. A phase length is taken only on the
    // transition into that phase, so later changes to t_* do not affect a
    // phase that is already running.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (neuron_trigger) begin
                    state_next = S_SAMPLE;
                    cnt_next   = load_val[0];
                end
            end
            S_SAMPLE: begin
                if (cnt_reg == '0) begin
                    state_next = S_INTEG;
                    cnt_next   = load_val[1];
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_INTEG: begin
                if (cnt_reg == '0) begin
                    state_next = S_LATCH;
                    cnt_next   = load_val[2];
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            S_LATCH: begin
                if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A trigger that arrives while busy takes priority over a clear in the
    // same cycle, so that event is never lost.
    always_comb begin
        overrun_next = overrun_reg;
        if (neuron_trigger && (state_reg != S_IDLE)) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end
    end

    // The outputs are decoded from state_next and then registered. This
    // makes the enables change on the same edge as the state register, so a
    // trigger in cycle N produces sample_en=1 and neuron_idle=0 in cycle N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            overrun_reg     <= 1'b0;
            neuron_idle_reg <= 1'b1;
            sample_en_reg   <= 1'b0;
            integ_en_reg    <= 1'b0;
            latch_en_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            overrun_reg     <= overrun_next;
            neuron_idle_reg <= (state_next == S_IDLE);
            sample_en_reg   <= (state_next == S_SAMPLE);
            integ_en_reg    <= (state_next == S_INTEG);
            latch_en_reg    <= (state_next == S_LATCH);
        end
    end

    assign neuron_idle = neuron_idle_reg;
    assign sample_en   = sample_en_reg;
    assign integ_en    = integ_en_reg;
    assign latch_en    = latch_en_reg;
    assign overrun     = overrun_reg;

`ifdef NEURON_OPCNT_EN
    // An operation counts as complete on the LATCH -> IDLE transition.
    // The counter wraps naturally at 2^OPS_W.
    logic             op_done;
    logic [OPS_W-1:0] op_count_reg;

    assign op_done = (state_reg == S_LATCH) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (op_done) begin
            op_count_reg <= op_count_reg + {{(OPS_W-1){1'b0}}, 1'b1};
        end
    end

    assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_neuron_pulse_responder.sv
// -----------------------------------------------------------------------------
// tb_neuron_pulse_responder
//
// Self-checking bench for neuron_pulse_responder.
//
// The reference model describes each operation by its trigger cycle and its
// three phase lengths. Every phase length is captured when its phase begins.
// The expected output for any cycle is found from that cycle's offset into
// the current operation.
//
// The op_count checks are built only when NEURON_OPCNT_EN is defined; in
// that case the bench sets OPS_W to 4.
// -----------------------------------------------------------------------------
module tb_neuron_pulse_responder;

    localparam int CNT_W = 16;
`ifdef NEURON_OPCNT_EN
    localparam int OPS_W = 4;
`endif
    // Large sentinel length for a phase that has not started yet.
    localparam int UNK = 1 << 20;

    logic             clk;
    logic             rst_n;
    logic             neuron_trigger;
    logic [CNT_W-1:0] t_sample;
    logic [CNT_W-1:0] t_integ;
    logic [CNT_W-1:0] t_latch;
    logic             overrun_clr;
    logic             neuron_idle;
    logic             sample_en;
    logic             integ_en;
    logic             latch_en;
    logic             overrun;
`ifdef NEURON_OPCNT_EN
    logic [OPS_W-1:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    neuron_pulse_responder #(
        .CNT_W(CNT_W)
`ifdef NEURON_OPCNT_EN
        ,
        .OPS_W(OPS_W)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .neuron_trigger(neuron_trigger),
        .t_sample      (t_sample),
        .t_integ       (t_integ),
        .t_latch       (t_latch),
        .overrun_clr   (overrun_clr),
        .neuron_idle   (neuron_idle),
        .sample_en     (sample_en),
        .integ_en      (integ_en),
        .latch_en      (latch_en),
        .overrun       (overrun)
`ifdef NEURON_OPCNT_EN
        ,
        .op_count      (op_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int cyc = 0;      // index of the current cycle (counts posedges)
    bit m_active = 0; // an operation has been launched and not yet retired
    int m_n = 0;      // cycle in which that operation's trigger was seen
    int m_a = 1;      // SAMPLE length
    int m_b = 1;      // INTEG length
    int m_c = 1;      // LATCH length
    bit m_ovr = 0;
    int m_ops = 0;
    int m_e;
    bit m_busy_e;

    function automatic int len1(input logic [CNT_W-1:0] t);
        return (t == '0) ? 1 : int'(t);
    endfunction

    function automatic bit m_busy(input int c);
        int k;
        k = c - m_n;
        return m_active && (k >= 1) && (k <= m_a + m_b + m_c);
    endfunction

    // Expected output vector for the current cycle, in the order
    // {neuron_idle, sample_en, integ_en, latch_en, overrun}.
    function automatic logic [4:0] m_expect();
        int k;
        k = cyc - m_n;
        if (!rst_n || !m_busy(cyc)) return {1'b1, 3'b000, m_ovr};
        if (k <= m_a)               return {1'b0, 3'b100, m_ovr};
        if (k <= m_a + m_b)         return {1'b0, 3'b010, m_ovr};
        return {1'b0, 3'b001, m_ovr};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_ovr    = 0;
            m_ops    = 0;
        end else begin
            m_e      = cyc;
            m_busy_e = m_busy(m_e);
            if (m_active) begin
                if (m_e == m_n + m_a)       m_b = len1(t_integ);
                if (m_e == m_n + m_a + m_b) m_c = len1(t_latch);
                if (m_e == m_n + m_a + m_b + m_c) begin
                    m_ops    = m_ops + 1;
                    m_active = 0;
                end
            end
            if (neuron_trigger && !m_busy_e) begin
                m_active = 1;
                m_n      = m_e;
                m_a      = len1(t_sample);
                m_b      = UNK;
                m_c      = UNK;
            end
            if (neuron_trigger && m_busy_e) m_ovr = 1;
            else if (overrun_clr)           m_ovr = 0;
            cyc = cyc + 1;
        end
    end

    function automatic logic [4:0] dut_vec();
        return {neuron_idle, sample_en, integ_en, latch_en, overrun};
    endfunction

    // ---------------------------------------------------------------------
    // Tests (inputs driven and outputs checked on the negedge)
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n          = 1'b0;
        neuron_trigger = 1'b0;
        overrun_clr    = 1'b0;
        t_sample       = '0;
        t_integ        = '0;
        t_latch        = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
`ifdef NEURON_OPCNT_EN
        checks++;
        if (op_count !== '0) begin
            errors++;
            $display("FAIL reset_opcount got=%0d exp=0", op_count);
        end
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== 5'b10000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=10000", i, dut_vec());
            end
        end
    endtask

    // t = 3/5/2. The expected schedule is written out from the phase lengths.
    task automatic test_basic();
        logic [4:0] exp_v;
        t_sample = 16'd3;
        t_integ  = 16'd5;
        t_latch  = 16'd2;
        neuron_trigger = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            neuron_trigger = 1'b0;
            if      (j <= 3)  exp_v = 5'b01000;
            else if (j <= 8)  exp_v = 5'b00100;
            else if (j <= 10) exp_v = 5'b00010;
            else              exp_v = 5'b10000;
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL basic_352 offs=%0d got=%b exp=%b", j, dut_vec(), exp_v);
            end
        end
    endtask

    // All lengths 0, so each phase lasts one cycle.
    task automatic test_zero();
        logic [4:0] exp_v;
        t_sample = '0;
        t_integ  = '0;
        t_latch  = '0;
        neuron_trigger = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            neuron_trigger = 1'b0;
            case (j)
                1:       exp_v = 5'b01000;
                2:       exp_v = 5'b00100;
                3:       exp_v = 5'b00010;
                default: exp_v = 5'b10000;
            endcase
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL zero_len offs=%0d got=%b exp=%b", j, dut_vec(), exp_v);
            end
        end
    endtask

    // t = 4 each. A second trigger two cycles into the operation must not
    // disturb it and must set overrun. Then: clear, set-beats-clear, clear.
    task automatic test_overrun();
        logic [4:0] exp_v;
        t_sample = 16'd4;
        t_integ  = 16'd4;
        t_latch  = 16'd4;
        neuron_trigger = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            neuron_trigger = (j == 2);
            if      (j <= 4)  exp_v = 5'b01000;
            else if (j <= 8)  exp_v = 5'b00100;
            else if (j <= 12) exp_v = 5'b00010;
            else              exp_v = 5'b10000;
            exp_v[0] = (j >= 3);
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL overrun_seq offs=%0d got=%b exp=%b", j, dut_vec(), exp_v);
            end
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr got=%b exp=0", overrun);
        end
        // Start an operation, then trigger and clear together while busy.
        neuron_trigger = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        neuron_trigger = 1'b0;
        overrun_clr    = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins got=%b exp=1", overrun);
        end
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++;
                $display("FAIL overrun_tail offs=%0d got=%b exp=%b", j, dut_vec(), m_expect());
            end
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    // Reset asserted mid-cycle during INTEG must drop the enables at once.
    task automatic test_reset_mid();
        t_sample = 16'd3;
        t_integ  = 16'd5;
        t_latch  = 16'd2;
        neuron_trigger = 1'b1;
        @(negedge clk);
        neuron_trigger = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (integ_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got=%b exp=1", integ_en);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_async got=%b exp=10000", dut_vec());
        end
        @(negedge clk);
        rst_n    = 1'b1;
        t_sample = 16'd2;
        t_integ  = 16'd2;
        t_latch  = 16'd2;
        neuron_trigger = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            neuron_trigger = 1'b0;
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++;
                $display("FAIL rstmid_post offs=%0d got=%b exp=%b", j, dut_vec(), m_expect());
            end
        end
    endtask

    // Random triggers, clears and lengths. The lengths also change mid-phase.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            neuron_trigger = ($urandom_range(0, 3) == 0);
            overrun_clr    = ($urandom_range(0, 7) == 0);
            t_sample       = 16'($urandom_range(0, 6));
            t_integ        = 16'($urandom_range(0, 6));
            t_latch        = 16'($urandom_range(0, 6));
            @(negedge clk);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_expect());
            end
        end
        neuron_trigger = 1'b0;
        overrun_clr    = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    // 17 back-to-back operations with t = 1, each triggered in the first idle
    // cycle. Each operation is 3 busy cycles plus 1 idle cycle, so the 17th
    // trigger lands 64 cycles after the first.
    task automatic test_back_to_back();
        int starts;
        int last_j;
        int ops_before;
        starts = 0;
        last_j = -1;
        ops_before = m_ops;
        t_sample = 16'd1;
        t_integ  = 16'd1;
        t_latch  = 16'd1;
`ifdef NEURON_OPCNT_EN
        begin : b_opcnt_before
            logic [OPS_W-1:0] opc0;
            opc0 = op_count;
`endif
        for (int j = 0; j < 100 && starts < 17; j++) begin
            neuron_trigger = neuron_idle;
            if (neuron_idle) begin
                starts++;
                last_j = j;
            end
            @(negedge clk);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, dut_vec(), m_expect());
            end
        end
        neuron_trigger = 1'b0;
        checks++;
        if (last_j !== 64) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=64", last_j);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (m_ops - ops_before !== 17) begin
            errors++;
            $display("FAIL b2b_ops got=%0d exp=17", m_ops - ops_before);
        end
`ifdef NEURON_OPCNT_EN
            checks++;
            if (4'(op_count - opc0) !== 4'd1) begin
                errors++;
                $display("FAIL b2b_opcount got=%0d exp=1", 4'(op_count - opc0));
            end
            checks++;
            if (op_count !== 4'(m_ops)) begin
                errors++;
                $display("FAIL opcount_model got=%0d exp=%0d", op_count, 4'(m_ops));
            end
        end
`endif
    endtask

    // An initiator loop: pulse the trigger, expect busy on the next cycle,
    // then wait (with a bound) for idle.
    task automatic test_handshake();
        int w;
        for (int h = 0; h < 8; h++) begin
            t_sample = 16'($urandom_range(0, 3));
            t_integ  = 16'($urandom_range(0, 3));
            t_latch  = 16'($urandom_range(0, 3));
            neuron_trigger = 1'b1;
            @(negedge clk);
            neuron_trigger = 1'b0;
            checks++;
            if (neuron_idle !== 1'b0) begin
                errors++;
                $display("FAIL hs_busy h=%0d got=%b exp=0", h, neuron_idle);
            end
            w = 0;
            while (neuron_idle !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
                checks++;
                if (dut_vec() !== m_expect()) begin
                    errors++;
                    $display("FAIL hs_seq h=%0d got=%b exp=%b", h, dut_vec(), m_expect());
                end
            end
            checks++;
            if (neuron_idle !== 1'b1) begin
                errors++;
                $display("FAIL hs_timeout h=%0d got=%b exp=1", h, neuron_idle);
            end
        end
    endtask

    // A full-scale SAMPLE length gives exactly 2^16-1 cycles, with no wrap.
    task automatic test_fullscale();
        int n;
        t_sample = 16'hFFFF;
        t_integ  = '0;
        t_latch  = '0;
        neuron_trigger = 1'b1;
        @(negedge clk);
        neuron_trigger = 1'b0;
        n = 0;
        while (sample_en === 1'b1 && n < 70000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 65535) begin
            errors++;
            $display("FAIL fullscale_len got=%0d exp=65535", n);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++;
                $display("FAIL fullscale_tail offs=%0d got=%b exp=%b", j, dut_vec(), m_expect());
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overrun();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_handshake();
        test_fullscale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
